// File: rtl/carry_skip_adder_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module      : carry_skip_adder_pipe_if
//  Description : Operand/result handshake bundle for carry_skip_adder_pipe.
//                slave  = the adder (consumes operands, produces results)
//                master = the environment driving operands / taking results
//  Signals     : in_valid/in_ready, a, b, cin, sub       (operand side)
//                out_valid/out_ready, sum, cout, ovf,
//                skip_mask                               (result side)
//  Revision    : 1.0 - initial release
// ============================================================================
interface carry_skip_adder_pipe_if #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
);
    localparam int NBLK = WIDTH / BLOCK;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic [NBLK-1:0]  skip_mask;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, skip_mask
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, skip_mask
    );
endinterface
`default_nettype wire

// File: rtl/carry_skip_adder_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : carry_skip_adder_pipe
//  Description : Pipelined carry-skip adder/subtractor. WIDTH-bit operands are
//                processed BLOCK bits per stage (NBLK = WIDTH/BLOCK stages).
//                Each stage ripples its block, and selects the incoming carry
//                instead of the ripple carry when the whole block propagates.
//                Valid/ready flow control per stage with bubble compression.
//  Ports       : clk        - clock, rising edge
//                rst_n      - asynchronous active-low reset
//                bus        - carry_skip_adder_pipe_if.slave (operands in,
//                             sum/cout/ovf/skip_mask out)
//  Revision    : 1.0 - initial release
// ============================================================================
module carry_skip_adder_pipe #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input  wire logic                    clk,
    input  wire logic                    rst_n,
    carry_skip_adder_pipe_if.slave       bus
);
    localparam int NBLK = WIDTH / BLOCK;

    // Subtraction: invert b and force the carry-in.
    logic [WIDTH-1:0] w_bp;
    logic             w_c0;
    assign w_bp = bus.sub ? ~bus.b : bus.b;
    assign w_c0 = bus.sub | bus.cin;

    // Per-stage valid bits and the backward ready chain.
    // w_rdy[k] means stage k can load this cycle.
    logic [NBLK-1:0] w_v;
    logic [NBLK:0]   w_rdy;

    always_comb begin
        w_rdy       = '0;
        w_rdy[NBLK] = bus.out_ready;
        for (int k = NBLK - 1; k >= 0; k--) begin
            w_rdy[k] = ~w_v[k] | w_rdy[k+1];
        end
    end

    assign bus.in_ready = w_rdy[0];

    for (genvar k = 0; k < NBLK; k++) begin : g_stage
        localparam int LO = k * BLOCK;     // first bit handled here
        localparam int UW = WIDTH - LO;    // operand bits still to process
        localparam int SW = LO + BLOCK;    // sum bits known after this stage

        // Upstream view: remaining operands, incoming carry, valid.
        logic [UW-1:0]    w_ua;
        logic [UW-1:0]    w_ub;
        logic             w_uc;
        logic             w_uv;
        logic             w_ld;

        logic [BLOCK-1:0] w_bs;
        logic             w_rc;
        logic             w_p;
        logic             w_co;

        logic             r_v;
        logic             r_c;
        logic [SW-1:0]    r_sum;
        logic [k:0]       r_skip;

        always_comb begin : p_ripple
            logic c;
            c    = w_uc;
            w_bs = '0;
            for (int i = 0; i < BLOCK; i++) begin
                w_bs[i] = w_ua[i] ^ w_ub[i] ^ c;
                c       = (w_ua[i] & w_ub[i]) | (c & (w_ua[i] ^ w_ub[i]));
            end
            w_rc = c;
        end

        assign w_p    = &(w_ua[BLOCK-1:0] ^ w_ub[BLOCK-1:0]);
        assign w_co   = w_p ? w_uc : w_rc;
        assign w_ld   = w_rdy[k] & w_uv;
        assign w_v[k] = r_v;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_v <= 1'b0;
                r_c <= 1'b0;
            end else begin
                if (w_rdy[k]) begin
                    r_v <= w_uv;
                end
                if (w_ld) begin
                    r_c <= w_co;
                end
            end
        end

        if (k == 0) begin : g_head
            assign w_ua = bus.a;
            assign w_ub = w_bp;
            assign w_uc = w_c0;
            assign w_uv = bus.in_valid;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_sum  <= '0;
                    r_skip <= '0;
                end else if (w_ld) begin
                    r_sum  <= w_bs;
                    r_skip <= w_p;
                end
            end
        end else begin : g_body
            assign w_ua = g_stage[k-1].g_ops.r_a;
            assign w_ub = g_stage[k-1].g_ops.r_b;
            assign w_uc = g_stage[k-1].r_c;
            assign w_uv = g_stage[k-1].r_v;

            // Lower sum bits and skip flags ride along with the beat.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_sum  <= '0;
                    r_skip <= '0;
                end else if (w_ld) begin
                    r_sum  <= {w_bs, g_stage[k-1].r_sum};
                    r_skip <= {w_p, g_stage[k-1].r_skip};
                end
            end
        end

        if (k < NBLK - 1) begin : g_ops
            // Only the not-yet-processed operand bits move forward.
            logic [UW-BLOCK-1:0] r_a;
            logic [UW-BLOCK-1:0] r_b;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_ld) begin
                    r_a <= w_ua[UW-1:BLOCK];
                    r_b <= w_ub[UW-1:BLOCK];
                end
            end
        end else begin : g_last
            logic r_ovf;

            // Carry into the MSB is recovered as a ^ b' ^ sum at that bit.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_ovf <= 1'b0;
                end else if (w_ld) begin
                    r_ovf <= w_ua[BLOCK-1] ^ w_ub[BLOCK-1] ^ w_bs[BLOCK-1] ^ w_co;
                end
            end

            assign bus.out_valid = r_v;
            assign bus.sum       = r_sum;
            assign bus.cout      = r_c;
            assign bus.ovf       = r_ovf;
            assign bus.skip_mask = r_skip;
        end
    end
endmodule
`default_nettype wire
